game_tick_gen: RTL



---
 rtl/game_tick_gen.sv | 128 ++++++++++++
 1 files changed

// File: rtl/game_tick_gen.sv
// game_tick_gen: end-of-frame detector and per-channel update tick divider.
// Optional macro GAME_TICK_SKIP_CNT_EN adds the skip_cnt merged-tick counters.
module game_tick_gen #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 4,
    parameter int X_W    = 10,
    parameter int Y_W    = 10,
    parameter int LAST_X = 639,
    parameter int LAST_Y = 479
) (
    input  logic                    in_clk,
    input  logic                    sys_reset_n,
    input  logic [X_W-1:0]          x_in,
    input  logic [Y_W-1:0]          y_in,
    input  logic [NUM_CH*CNT_W-1:0] period_in,
    input  logic [NUM_CH-1:0]       ch_en,
    input  logic                    pause,
    input  logic [NUM_CH-1:0]       ready_in,
    output logic [NUM_CH-1:0]       tick_out,
    output logic [NUM_CH-1:0]       pending_out,
`ifdef GAME_TICK_SKIP_CNT_EN
    output logic [NUM_CH*8-1:0]     skip_cnt,
`endif
    output logic [15:0]             frame_cnt
);

    logic                               match;
    logic                               match_q, match_d;
    logic                               arm_q, arm_d;
    logic                               fp_q, fp_d;
    logic [15:0]                        fcnt_q, fcnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_CH-1:0][CNT_W-1:0]       shp_q, shp_d;
    logic [NUM_CH-1:0]                  due;
    logic [NUM_CH-1:0]                  pend_q, pend_d;
    logic [NUM_CH-1:0]                  tick_q, tick_d;
`ifdef GAME_TICK_SKIP_CNT_EN
    logic [NUM_CH-1:0][7:0]             skip_q, skip_d;
`endif

    // Frame-end detection; arm blocks a pulse until match has been seen low
    // after reset, so a coordinate parked on the last pixel is not a new frame.
    always_comb begin
        match   = (x_in == X_W'(LAST_X)) && (y_in == Y_W'(LAST_Y));
        match_d = match;
        arm_d   = arm_q | ~match;
        fp_d    = match & ~match_q & arm_q;
        fcnt_d  = fcnt_q + {15'd0, fp_q};
    end

    // Per-channel divider, shadow period reload and ready handshake.
    always_comb begin
        cnt_d  = cnt_q;
        shp_d  = shp_q;
        due    = '0;
        tick_d = '0;
        pend_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) begin
                cnt_d[i] = '0;
                shp_d[i] = period_in[i*CNT_W +: CNT_W];
            end else if (fp_q && !pause) begin
                if (cnt_q[i] == shp_q[i]) begin
                    cnt_d[i] = '0;
                    shp_d[i] = period_in[i*CNT_W +: CNT_W];
                    due[i]   = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
            tick_d[i] = ch_en[i] & ready_in[i] & (due[i] | pend_q[i]);
            pend_d[i] = ch_en[i] & ~ready_in[i] & (due[i] | pend_q[i]);
        end
    end

`ifdef GAME_TICK_SKIP_CNT_EN
    // Saturating count of ticks that merged into an already-pending one.
    always_comb begin
        skip_d = skip_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!ch_en[i]) begin
                skip_d[i] = '0;
            end else if (due[i] && pend_q[i] && skip_q[i] != 8'hFF) begin
                skip_d[i] = skip_q[i] + 8'd1;
            end
        end
    end

    // Skip counter state.
    always_ff @(posedge in_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            skip_q <= '0;
        end else begin
            skip_q <= skip_d;
        end
    end

    assign skip_cnt = skip_q;
`endif

    // Main state registers.
    always_ff @(posedge in_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            match_q <= 1'b0;
            arm_q   <= 1'b0;
            fp_q    <= 1'b0;
            fcnt_q  <= '0;
            cnt_q   <= '0;
            shp_q   <= '0;
            pend_q  <= '0;
            tick_q  <= '0;
        end else begin
            match_q <= match_d;
            arm_q   <= arm_d;
            fp_q    <= fp_d;
            fcnt_q  <= fcnt_d;
            cnt_q   <= cnt_d;
            shp_q   <= shp_d;
            pend_q  <= pend_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_out    = tick_q;
    assign pending_out = pend_q;
    assign frame_cnt   = fcnt_q;

endmodule
